// File: rtl/vectadd_oci_dct_pkg.sv
// Shared widths, atom codes and frame parity helper for the OCI DCT packer.
// Imported by vectadd_nios2_qsys_0_oci_dct_packer and its frame register.
package vectadd_oci_dct_pkg;

  localparam int DCT_ATOM_W    = 2;
  localparam int DCT_MAX_ATOMS = 15;
  localparam int DCT_BUF_W     = 30;
  localparam int DCT_CNT_W     = 4;

  typedef enum logic [DCT_ATOM_W-1:0] {
    NOP   = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    SYNC  = 2'd3
  } dct_atom_e;

  function automatic logic dct_parity(
    input logic [DCT_BUF_W-1:0] data,
    input logic [DCT_CNT_W-1:0] count
  );
    return ^{data, count};
  endfunction

endpackage

// File: rtl/vectadd_oci_dct_frame_reg.sv
// One-entry valid/ready holding register for packed DCT frames.
// Ports: load/load_data/load_count in, valid/data/count out, ready in; parity with VECTADD_OCI_DCT_PARITY_EN.
module vectadd_oci_dct_frame_reg
  import vectadd_oci_dct_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [DCT_BUF_W-1:0] load_data,
  input  logic [DCT_CNT_W-1:0] load_count,
  input  logic                 ready,
  output logic                 valid,
  output logic [DCT_BUF_W-1:0] data,
  output logic [DCT_CNT_W-1:0] count
`ifdef VECTADD_OCI_DCT_PARITY_EN
  ,
  output logic                 parity
`endif
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
      count <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      count <= load_count;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

`ifdef VECTADD_OCI_DCT_PARITY_EN
  // Parity travels with the frame so it holds while data holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity <= 1'b0;
    end else if (load) begin
      parity <= dct_parity(load_data, load_count);
    end
  end
`endif

endmodule

// File: rtl/vectadd_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit trace atoms LSB-first into 30-bit frames with a 4-bit count.
// Ports: atm_valid/atm_code/atm_ready in, flush, live dct_buffer/dct_count, frame_* out; parity with VECTADD_OCI_DCT_PARITY_EN.
module vectadd_nios2_qsys_0_oci_dct_packer
  import vectadd_oci_dct_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  atm_valid,
  input  logic [DCT_ATOM_W-1:0] atm_code,
  output logic                  atm_ready,
  input  logic                  flush,
  output logic [DCT_BUF_W-1:0]  dct_buffer,
  output logic [DCT_CNT_W-1:0]  dct_count,
  output logic                  frame_valid,
  output logic [DCT_BUF_W-1:0]  frame_data,
  output logic [DCT_CNT_W-1:0]  frame_count,
  input  logic                  frame_ready
`ifdef VECTADD_OCI_DCT_PARITY_EN
  ,
  output logic                  frame_parity
`endif
);

  logic                 flush_pend;
  logic                 out_free;
  logic                 full;
  logic                 acc;
  logic                 launch;
  logic [DCT_BUF_W-1:0] ins;

  always_comb begin
    out_free  = !frame_valid || frame_ready;
    full      = dct_count == DCT_CNT_W'(DCT_MAX_ATOMS);
    atm_ready = !full || out_free;
    acc       = atm_valid && atm_ready;
    launch    = out_free &&
                (full || ((flush || flush_pend) && dct_count != '0));
    ins = '0;
    for (int i = 0; i < DCT_MAX_ATOMS; i++) begin
      if (dct_count == DCT_CNT_W'(i)) begin
        ins[DCT_ATOM_W*i +: DCT_ATOM_W] = atm_code;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dct_buffer <= '0;
      dct_count  <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (launch) begin
        // A refill atom on the launch cycle becomes slot 0.
        dct_buffer <= acc ? DCT_BUF_W'(atm_code) : '0;
        dct_count  <= acc ? DCT_CNT_W'(1) : '0;
      end else if (acc) begin
        dct_buffer <= dct_buffer | ins;
        dct_count  <= dct_count + DCT_CNT_W'(1);
      end
      // Flush on an empty buffer is kept only if an atom arrives with it.
      if (launch) begin
        flush_pend <= 1'b0;
      end else if (dct_count == '0 && !acc) begin
        flush_pend <= 1'b0;
      end else begin
        flush_pend <= flush || flush_pend;
      end
    end
  end

  vectadd_oci_dct_frame_reg u_frame_reg (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (launch),
    .load_data  (dct_buffer),
    .load_count (dct_count),
    .ready      (frame_ready),
    .valid      (frame_valid),
    .data       (frame_data),
    .count      (frame_count)
`ifdef VECTADD_OCI_DCT_PARITY_EN
    ,
    .parity     (frame_parity)
`endif
  );

endmodule

// File: tb/tb_vectadd_nios2_qsys_0_oci_dct_packer.sv
// Self-checking bench for the OCI DCT packer: directed scenarios plus random traffic.
// Random traffic is checked against an atom-stream scoreboard; parity checked with VECTADD_OCI_DCT_PARITY_EN.
module tb_vectadd_nios2_qsys_0_oci_dct_packer;
  import vectadd_oci_dct_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  atm_valid;
  logic [DCT_ATOM_W-1:0] atm_code;
  logic                  atm_ready;
  logic                  flush;
  logic [DCT_BUF_W-1:0]  dct_buffer;
  logic [DCT_CNT_W-1:0]  dct_count;
  logic                  frame_valid;
  logic [DCT_BUF_W-1:0]  frame_data;
  logic [DCT_CNT_W-1:0]  frame_count;
  logic                  frame_ready;
`ifdef VECTADD_OCI_DCT_PARITY_EN
  logic                  frame_parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bit        mon_en = 1'b0;
  int        acc_q[$];
  logic [33:0] fr_q[$];

  vectadd_nios2_qsys_0_oci_dct_packer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .atm_valid    (atm_valid),
    .atm_code     (atm_code),
    .atm_ready    (atm_ready),
    .flush        (flush),
    .dct_buffer   (dct_buffer),
    .dct_count    (dct_count),
    .frame_valid  (frame_valid),
    .frame_data   (frame_data),
    .frame_count  (frame_count),
    .frame_ready  (frame_ready)
`ifdef VECTADD_OCI_DCT_PARITY_EN
    ,
    .frame_parity (frame_parity)
`endif
  );

  always #5 clk = ~clk;

  // Record handshakes mid-cycle; inputs and registered outputs are stable here.
  always @(negedge clk) begin
    if (mon_en) begin
      if (atm_valid && atm_ready) acc_q.push_back(int'(atm_code));
      if (frame_valid && frame_ready) fr_q.push_back({frame_count, frame_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    atm_valid = 1'b0;
    flush = 1'b0;
    frame_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [DCT_BUF_W-1:0] pack(input int codes[$]);
    longint v = 0;
    for (int i = 0; i < codes.size(); i++) v += longint'(codes[i]) << (2 * i);
    return DCT_BUF_W'(v);
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    atm_valid = 1'b0;
    atm_code = '0;
    flush = 1'b0;
    frame_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({dct_buffer, dct_count, frame_valid, frame_data, frame_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got buf=%h cnt=%0d fv=%b fd=%h fc=%0d, need all 0",
               dct_buffer, dct_count, frame_valid, frame_data, frame_count);
    end
    n_checks++;
    if (atm_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_atm_ready: got %b need 1", atm_ready);
    end
    #2 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_full_frame();
    int codes[$];
    frame_ready = 1'b1;
    atm_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      atm_code = DCT_ATOM_W'((i + 1) % 4);
      codes.push_back((i + 1) % 4);
      tick();
    end
    atm_valid = 1'b0;
    n_checks++;
    if (dct_count !== 4'd15 || frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pre_launch: got cnt=%0d fv=%b need 15/0", dct_count, frame_valid);
    end
    tick();
    n_checks++;
    if (frame_valid !== 1'b1 || frame_count !== 4'd15) begin
      n_fail++;
      $display("FAIL full_launch: got fv=%b fc=%0d need 1/15", frame_valid, frame_count);
    end
    n_checks++;
    if (frame_data !== pack(codes)) begin
      n_fail++;
      $display("FAIL full_data: got %h need %h", frame_data, pack(codes));
    end
    n_checks++;
    if (dct_count !== 4'd0 || dct_buffer !== '0) begin
      n_fail++;
      $display("FAIL full_clear: got cnt=%0d buf=%h need 0/0", dct_count, dct_buffer);
    end
    idle(2);
  endtask

  task automatic test_flush();
    int codes[$] = '{3, 3, 1};
    atm_valid = 1'b1;
    foreach (codes[i]) begin
      atm_code = DCT_ATOM_W'(codes[i]);
      tick();
    end
    atm_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (frame_valid !== 1'b1 || frame_count !== 4'd3 || frame_data !== 30'h1F) begin
      n_fail++;
      $display("FAIL flush_frame: got fv=%b fc=%0d fd=%h need 1/3/1f",
               frame_valid, frame_count, frame_data);
    end
    n_checks++;
    if (dct_count !== 4'd0) begin
      n_fail++;
      $display("FAIL flush_count: got %0d need 0", dct_count);
    end
    idle(2);
  endtask

  task automatic test_stall();
    int a[$];
    int b[$];
    int c0;
    frame_ready = 1'b0;
    atm_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      a.push_back(int'($urandom_range(0, 3)));
      atm_code = DCT_ATOM_W'(a[i]);
      tick();
    end
    atm_valid = 1'b0;
    tick();
    n_checks++;
    if (frame_valid !== 1'b1 || frame_data !== pack(a)) begin
      n_fail++;
      $display("FAIL stall_first: got fv=%b fd=%h need 1/%h", frame_valid, frame_data, pack(a));
    end
    atm_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      b.push_back(int'($urandom_range(0, 3)));
      atm_code = DCT_ATOM_W'(b[i]);
      tick();
    end
    atm_code = 2'd2;
    tick();
    tick();
    n_checks++;
    if (atm_ready !== 1'b0 || dct_count !== 4'd15) begin
      n_fail++;
      $display("FAIL stall_backpressure: got rdy=%b cnt=%0d need 0/15", atm_ready, dct_count);
    end
    n_checks++;
    if (frame_data !== pack(a) || dct_buffer !== pack(b)) begin
      n_fail++;
      $display("FAIL stall_hold: got fd=%h buf=%h need %h/%h",
               frame_data, dct_buffer, pack(a), pack(b));
    end
    c0 = int'($urandom_range(0, 3));
    atm_code = DCT_ATOM_W'(c0);
    frame_ready = 1'b1;
    #1;
    n_checks++;
    if (atm_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release_ready: got %b need 1", atm_ready);
    end
    tick();
    atm_valid = 1'b0;
    n_checks++;
    if (frame_valid !== 1'b1 || frame_count !== 4'd15 || frame_data !== pack(b)) begin
      n_fail++;
      $display("FAIL stall_second: got fv=%b fc=%0d fd=%h need 1/15/%h",
               frame_valid, frame_count, frame_data, pack(b));
    end
    n_checks++;
    if (dct_count !== 4'd1 || dct_buffer !== DCT_BUF_W'(c0)) begin
      n_fail++;
      $display("FAIL stall_refill: got cnt=%0d buf=%h need 1/%0d", dct_count, dct_buffer, c0);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (frame_valid !== 1'b1 || frame_count !== 4'd1 || frame_data !== DCT_BUF_W'(c0)) begin
      n_fail++;
      $display("FAIL stall_tail: got fv=%b fc=%0d fd=%h need 1/1/%0d",
               frame_valid, frame_count, frame_data, c0);
    end
    idle(2);
  endtask

  task automatic test_flush_empty();
    int c;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (frame_valid !== 1'b0 || dut.flush_pend !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_empty: got fv=%b pend=%b need 0/0", frame_valid, dut.flush_pend);
    end
    c = int'($urandom_range(0, 3));
    atm_code = DCT_ATOM_W'(c);
    atm_valid = 1'b1;
    flush = 1'b1;
    tick();
    atm_valid = 1'b0;
    flush = 1'b0;
    n_checks++;
    if (frame_valid !== 1'b0 || dct_count !== 4'd1 || dut.flush_pend !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_atom_pend: got fv=%b cnt=%0d pend=%b need 0/1/1",
               frame_valid, dct_count, dut.flush_pend);
    end
    tick();
    n_checks++;
    if (frame_valid !== 1'b1 || frame_count !== 4'd1 || frame_data !== DCT_BUF_W'(c) ||
        dct_count !== 4'd0) begin
      n_fail++;
      $display("FAIL flush_atom_launch: got fv=%b fc=%0d fd=%h cnt=%0d need 1/1/%0d/0",
               frame_valid, frame_count, frame_data, dct_count, c);
    end
    idle(2);
  endtask

  task automatic test_async_reset();
    int c;
    atm_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      atm_code = DCT_ATOM_W'($urandom_range(1, 3));
      tick();
    end
    atm_valid = 1'b0;
    n_checks++;
    if (dct_count !== 4'd7) begin
      n_fail++;
      $display("FAIL areset_fill: got cnt=%0d need 7", dct_count);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({dct_buffer, dct_count, frame_valid, frame_data, frame_count} !== '0) begin
      n_fail++;
      $display("FAIL areset_clear: got buf=%h cnt=%0d fv=%b fd=%h fc=%0d need all 0",
               dct_buffer, dct_count, frame_valid, frame_data, frame_count);
    end
    #2 reset_n = 1'b1;
    c = int'($urandom_range(1, 3));
    atm_code = DCT_ATOM_W'(c);
    atm_valid = 1'b1;
    tick();
    atm_valid = 1'b0;
    n_checks++;
    if (dct_count !== 4'd1 || dct_buffer !== DCT_BUF_W'(c)) begin
      n_fail++;
      $display("FAIL areset_refill: got cnt=%0d buf=%h need 1/%0d", dct_count, dct_buffer, c);
    end
    flush = 1'b1;
    tick();
    idle(2);
  endtask

`ifdef VECTADD_OCI_DCT_PARITY_EN
  task automatic test_parity();
    int codes[2] = '{1, 3};
    logic exp[2] = '{1'b0, 1'b1};
    foreach (codes[k]) begin
      atm_code = DCT_ATOM_W'(codes[k]);
      atm_valid = 1'b1;
      tick();
      atm_valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_checks++;
      if (frame_parity !== exp[k] || frame_data !== DCT_BUF_W'(codes[k])) begin
        n_fail++;
        $display("FAIL parity_%0d: got par=%b fd=%h need %b/%0d",
                 k, frame_parity, frame_data, exp[k], codes[k]);
      end
      idle(2);
    end
  endtask
`endif

  task automatic test_random();
    int got[$];
    int bad = 0;
    acc_q.delete();
    fr_q.delete();
    mon_en = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      atm_valid = ($urandom_range(0, 9) < 8);
      atm_code = DCT_ATOM_W'($urandom_range(0, 3));
      flush = ($urandom_range(0, 19) == 0);
      frame_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    atm_valid = 1'b0;
    frame_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    mon_en = 1'b0;
    foreach (fr_q[f]) begin
      int cnt = int'(fr_q[f][33:30]);
      logic [DCT_BUF_W-1:0] d = fr_q[f][29:0];
      if (cnt < 1 || cnt > 15 || (cnt < 15 && (d >> (2 * cnt)) != 0)) bad++;
      for (int i = 0; i < cnt; i++) got.push_back(int'((d >> (2 * i)) & 30'h3));
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL random_frame_shape: got %0d malformed frames need 0", bad);
    end
    n_checks++;
    if (got.size() != acc_q.size()) begin
      n_fail++;
      $display("FAIL random_atom_total: got %0d atoms out need %0d", got.size(), acc_q.size());
    end else begin
      bad = 0;
      foreach (got[i]) if (got[i] != acc_q[i]) bad++;
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL random_atom_order: got %0d mismatched atoms need 0", bad);
      end
    end
    n_checks++;
    if (dct_count !== 4'd0 || frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL random_drain: got cnt=%0d fv=%b need 0/0", dct_count, frame_valid);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_flush();
    test_stall();
    test_flush_empty();
    test_async_reset();
`ifdef VECTADD_OCI_DCT_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
